// File: rtl/sdp_ram_pkg.sv
// rtl/sdp_ram_pkg.sv - shared types, constants and lane-merge helper for sdp_ram_be_clr
package sdp_ram_pkg;

    // Clear sequencer states
    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Read-during-write behaviour selectors
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest word the merge helper handles; callers zero-extend into it
    localparam int MERGE_W = 256;

    // Per-lane merge: lanes with be set take new_word, the rest keep old_word
    function automatic logic [MERGE_W-1:0] lane_merge(
        input logic [MERGE_W-1:0] old_word,
        input logic [MERGE_W-1:0] new_word,
        input logic [MERGE_W-1:0] be,
        input int                 lane_width
    );
        logic [MERGE_W-1:0] merged;
        logic [7:0]         lane;
        for (int i = 0; i < MERGE_W; i++) begin
            lane      = 8'(i / lane_width);
            merged[i] = be[lane] ? new_word[i] : old_word[i];
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_clear_sequencer.sv
// rtl/ram_clear_sequencer.sv - clear sweep FSM and write-port arbitration
module ram_clear_sequencer
    import sdp_ram_pkg::*;
#(
    parameter int                   WIDTH_MEM      = 32,
    parameter int                   DEPTH_MEM      = 16,
    parameter int                   NUM_LANES      = 4,
    parameter int                   AW             = 4,
    parameter int                   CLEAR_ON_RESET = 1,
    parameter logic [WIDTH_MEM-1:0] CLEAR_VALUE    = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_req,
    input  logic                 wr_enable,
    input  logic [NUM_LANES-1:0] wr_be,
    input  logic [AW-1:0]        wr_address,
    input  logic [WIDTH_MEM-1:0] wr_data,
    input  logic                 rd_enable,
    output logic                 init_busy,
    output logic                 mem_we,
    output logic [NUM_LANES-1:0] mem_be,
    output logic [AW-1:0]        mem_addr,
    output logic [WIDTH_MEM-1:0] mem_data,
    output logic                 rd_accept
);

    localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH_MEM - 1);
    localparam clr_state_t    RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    clr_state_t    state;
    clr_state_t    state_next;
    logic [AW-1:0] clr_addr;
    logic [AW-1:0] clr_addr_next;
    logic          user_ok;

    // State and sweep address registers; reset restarts any sweep from entry 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RESET_STATE;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    // Next-state logic: one entry per cycle while clearing, requests ignored mid-sweep
    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        case (state)
            ST_READY: begin
                if (clear_req) begin
                    state_next    = ST_CLEAR;
                    clr_addr_next = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_addr == LAST_ADDR) begin
                    state_next    = ST_READY;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr + 1'b1;
                end
            end
            default: begin
                state_next    = RESET_STATE;
                clr_addr_next = '0;
            end
        endcase
    end

    // User traffic only passes in READY, and not in the cycle that requests a clear
    assign user_ok   = (state == ST_READY) && !clear_req && !rst;
    assign rd_accept = user_ok && rd_enable;

    // Write-port mux: the sweep owns the port while clearing, otherwise the user does
    always_comb begin
        init_busy = (state == ST_CLEAR);
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = wr_address;
        mem_data  = wr_data;
        if ((state == ST_CLEAR) && !rst) begin
            mem_we   = 1'b1;
            mem_be   = '1;
            mem_addr = clr_addr;
            mem_data = CLEAR_VALUE;
        end else if (user_ok && wr_enable) begin
            mem_we = 1'b1;
            mem_be = wr_be;
        end
    end

endmodule

// File: rtl/sdp_ram_be_clr.sv
// rtl/sdp_ram_be_clr.sv - simple-dual-port RAM with byte enables, read pipeline and clear sweep
module sdp_ram_be_clr
    import sdp_ram_pkg::*;
#(
    parameter int                   WIDTH_MEM      = 32,
    parameter int                   DEPTH_MEM      = 16,
    parameter int                   LANE_WIDTH     = 8,
    parameter int                   RD_LATENCY     = 1,
    parameter int                   RDW_MODE       = 0,
    parameter int                   CLEAR_ON_RESET = 1,
    parameter logic [WIDTH_MEM-1:0] CLEAR_VALUE    = '0,
    localparam int                  NUM_LANES      = WIDTH_MEM / LANE_WIDTH,
    localparam int                  AW             = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_req,
    output logic                 init_busy,
    input  logic                 wr_enable,
    input  logic [NUM_LANES-1:0] wr_be,
    input  logic [AW-1:0]        wr_address,
    input  logic [WIDTH_MEM-1:0] wr_data,
    input  logic                 rd_enable,
    input  logic [AW-1:0]        rd_address,
    output logic [WIDTH_MEM-1:0] rd_data,
    output logic                 rd_valid
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH_MEM);

    logic [WIDTH_MEM-1:0] mem [DEPTH_MEM];

    logic                 mem_we;
    logic [NUM_LANES-1:0] mem_be;
    logic [AW-1:0]        mem_addr;
    logic [WIDTH_MEM-1:0] mem_data;
    logic                 rd_accept;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic [WIDTH_MEM-1:0] rd_word;
    logic                 s1_valid;
    logic [WIDTH_MEM-1:0] s1_data;

    ram_clear_sequencer #(
        .WIDTH_MEM      (WIDTH_MEM),
        .DEPTH_MEM      (DEPTH_MEM),
        .NUM_LANES      (NUM_LANES),
        .AW             (AW),
        .CLEAR_ON_RESET (CLEAR_ON_RESET),
        .CLEAR_VALUE    (CLEAR_VALUE)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .wr_enable  (wr_enable),
        .wr_be      (wr_be),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .rd_enable  (rd_enable),
        .init_busy  (init_busy),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .rd_accept  (rd_accept)
    );

    assign wr_in_range = {1'b0, mem_addr} < DEPTH_L;
    assign rd_in_range = {1'b0, rd_address} < DEPTH_L;

    // Lane-granular write; out-of-range addresses are silently dropped
    always_ff @(posedge clk) begin
        if (mem_we && wr_in_range) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][i*LANE_WIDTH +: LANE_WIDTH] <= mem_data[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Read word selection, with same-cycle write bypass in write-first mode
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_address];
            if ((RDW_MODE == RDW_WRITE_FIRST) && mem_we && (mem_addr == rd_address)) begin
                rd_word = WIDTH_MEM'(lane_merge(MERGE_W'(mem[rd_address]), MERGE_W'(mem_data),
                                                MERGE_W'(mem_be), LANE_WIDTH));
            end
        end
    end

    // First read stage; data holds between accepted reads
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_accept;
            if (rd_accept) begin
                s1_data <= rd_word;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                 s2_valid;
        logic [WIDTH_MEM-1:0] s2_data;

        // Extra output register stage for the two-cycle latency build
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign rd_valid = s2_valid;
        assign rd_data  = s2_data;
    end else begin : g_lat1
        assign rd_valid = s1_valid;
        assign rd_data  = s1_data;
    end

endmodule

// File: doc/sdp_ram_be_clr.md
Name: sdp_ram_be_clr

Overview:
- Simple-dual-port synchronous RAM, next generation of the team's 8x16 storage block.
- Adds per-lane byte-enable writes, selectable read latency (1 or 2) with a read-valid strobe, and selectable read-during-write collision mode.
- Adds a hardware clear sequencer that fills every entry with a constant after reset or on request.
- Serves as backing store for UART TX/RX buffers and the command/status register file.

Parameters:
WIDTH_MEM, 32, word width in bits; must be a multiple of LANE_WIDTH
DEPTH_MEM, 16, number of words; need not be a power of two
LANE_WIDTH, 8, bits per byte-enable lane; NUM_LANES = WIDTH_MEM/LANE_WIDTH
RD_LATENCY, 1, rd_enable-to-rd_valid latency in cycles; legal values 1 or 2
RDW_MODE, 0, same-address read/write in one cycle: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (merged new data)
CLEAR_ON_RESET, 1, 1 = run a clear sweep after rst deasserts; 0 = go straight to READY
CLEAR_VALUE, 0, WIDTH_MEM-bit fill value written by a sweep

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
clear_req  in  1  one-cycle pulse requesting a clear sweep
init_busy  out  1  high while a sweep is in progress
wr_enable  in  1  write request
wr_be  in  NUM_LANES  lane write enables
wr_address  in  $clog2(DEPTH_MEM)  write address
wr_data  in  WIDTH_MEM  write data
rd_enable  in  1  read request
rd_address  in  $clog2(DEPTH_MEM)  read address
rd_data  out  WIDTH_MEM  read data; holds last value between reads
rd_valid  out  1  one-cycle strobe, rd_data valid

Behaviour:
- Reset values while rst is high: rd_data = 0, rd_valid = 0, all read pipeline stages flushed.
- State while rst is high: init_busy = CLEAR_ON_RESET, FSM = CLEAR (or READY if CLEAR_ON_RESET = 0), clr_addr = 0.
- Memory contents are not reset directly; they are only changed by a sweep.
- FSM states:
  - READY: user reads and writes accepted.
  - CLEAR: one entry per cycle gets CLEAR_VALUE at clr_addr; clr_addr increments.
  - Leaving CLEAR: after writing DEPTH_MEM-1, FSM goes to READY and init_busy drops on the next cycle.
  - Sweep length is exactly DEPTH_MEM cycles after rst deasserts (or after the clear_req cycle).
- READY + clear_req: enter CLEAR next cycle. Any rd_enable/wr_enable in the clear_req cycle or during CLEAR is dropped (no write, no rd_valid).
- clear_req during CLEAR: ignored; the sweep is not restarted.
- In-flight reads accepted before clear_req complete normally and return pre-clear data.
- Write: on a clk edge with wr_enable in READY, each lane i with wr_be[i] = 1 gets wr_data lane i; other lanes are kept. wr_be = 0 is a no-op.
- Read: rd_enable in READY is accepted.
  - RD_LATENCY = 1: rd_data/rd_valid update on the next edge.
  - RD_LATENCY = 2: an extra output register stage is added.
  - Full throughput: one read per cycle, back-to-back.
- Collision (rd_address == wr_address, both enabled, READY):
  - RDW_MODE 0: returns the old word.
  - RDW_MODE 1: returns the word after the write (byte-enable merged).
- Out-of-range address (>= DEPTH_MEM, non-power-of-two depth only): write ignored; read returns 0 with rd_valid asserted.
- rst mid-sweep or mid-read: sweep restarts from address 0 (if CLEAR_ON_RESET); pending reads are discarded and no rd_valid is produced for them.

Decomposition:
- Package sdp_ram_pkg holds:
  - FSM state encoding (ST_READY, ST_CLEAR)
  - RDW_READ_FIRST / RDW_WRITE_FIRST constants
  - lane-merge function: old, new, be -> merged word
- One natural sub-module, ram_clear_sequencer: FSM, clr_addr counter, init_busy, and the mux that selects sweep vs user write port.
- Array, read pipeline and collision bypass stay in the top module.

Test Plan:
1. Defaults; rst 1 cycle, then deasserted -> init_busy high exactly 16 cycles; then reading addresses 0..15 returns 0x00000000 with rd_valid one cycle after each rd_enable.
2. Write 0xDEADBEEF to address 3, then wr_be = 4'b0010 with wr_data = 0x0000AA00 to address 3 -> read of address 3 returns 0xDEADAAEF.
3. Address 5 holds 0x11111111; write 0x22222222 and read address 5 in the same cycle -> RDW_MODE 0 returns 0x11111111; RDW_MODE 1 returns 0x22222222.
4. RD_LATENCY = 2; back-to-back reads of addresses 0, 1, 2 preloaded with 0xA0, 0xA1, 0xA2 -> rd_valid high for 3 consecutive cycles starting 2 cycles after the first rd_enable, with data in order.
5. clear_req pulse with a read of address 7 (0x77) issued the cycle before it -> read returns 0x77; init_busy high for 16 cycles; a write issued during the sweep is dropped; address 7 then reads CLEAR_VALUE.
6. rst asserted for 1 cycle at sweep step 8 with an outstanding read -> no rd_valid for that read; sweep restarts at address 0 and finishes 16 cycles after rst deasserts.
